// File: rtl/dot_product_accumulator.sv
// Accumulates VEC_LEN signed products into one dot-product result, holds it
// until the consumer takes it, and tags each result with a wrapping sequence index.
module dot_product_accumulator #(
  parameter int DATA_WIDTH = 4,
  parameter int VEC_LEN    = 4,
  parameter int ACC_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH+3:0] in_product,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic                  out_overflow,
  output logic [7:0]            out_index
);

  localparam int         PW       = DATA_WIDTH + 4;
  localparam logic [7:0] LAST_IDX = 8'(VEC_LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
  logic                 out_ovf_q, out_ovf_d;
  logic [7:0]           out_index_q, out_index_d;

  logic signed [PW-1:0] prod_sgn_s;
  logic [ACC_WIDTH-1:0] prod_ext_s;
  logic [ACC_WIDTH-1:0] sum_s;
  logic                 step_ovf_s;

  assign prod_sgn_s = $signed(in_product);
  assign prod_ext_s = ACC_WIDTH'(prod_sgn_s);
  assign sum_s      = acc_q + prod_ext_s;
  assign step_ovf_s = add_overflow(acc_q[ACC_WIDTH-1], prod_ext_s[ACC_WIDTH-1], sum_s[ACC_WIDTH-1]);

  // in_ready depends only on the state register, never on out_ready.
  assign in_ready     = (state_q == ACCUM);
  assign out_valid    = out_valid_q;
  assign out_sum      = out_sum_q;
  assign out_overflow = out_ovf_q;
  assign out_index    = out_index_q;

  // Next-state and datapath update for both states.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_index_d = out_index_q;
    case (state_q)
      ACCUM: begin
        if (flush) begin
          acc_d = {ACC_WIDTH{1'b0}};
          cnt_d = 8'd0;
          ovf_d = 1'b0;
        end else if (in_valid) begin
          if (cnt_q == LAST_IDX) begin
            out_sum_d   = sum_s;
            out_ovf_d   = ovf_q | step_ovf_s;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            acc_d = sum_s;
            cnt_d = cnt_q + 8'd1;
            ovf_d = ovf_q | step_ovf_s;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      HOLD: begin
        // Flush is deliberately ignored here so the pending result is delivered.
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = {ACC_WIDTH{1'b0}};
          cnt_d       = 8'd0;
          ovf_d       = 1'b0;
          out_index_d = out_index_q + 8'd1;
          state_d     = ACCUM;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= {ACC_WIDTH{1'b0}};
      cnt_q       <= 8'd0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= {ACC_WIDTH{1'b0}};
      out_ovf_q   <= 1'b0;
      out_index_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_index_q <= out_index_d;
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: a 10-bit and an 8-bit accumulator share
// stimulus; each is checked every cycle against an integer model of the rules.
module tb_dot_product_accumulator;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_product;
  logic       flush;
  logic       out_ready;

  int checks;
  int failures;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int AW   = (g == 0) ? 10 : 8;
    localparam int MAXV = (1 << (AW - 1)) - 1;
    localparam int MINV = -(1 << (AW - 1));

    logic          rdy_l;
    logic          vld_l;
    logic [AW-1:0] sum_l;
    logic          ovf_l;
    logic [7:0]    idx_l;

    dot_product_accumulator #(.DATA_WIDTH(4), .VEC_LEN(4), .ACC_WIDTH(AW)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_l),
      .in_product(in_product), .flush(flush), .out_valid(vld_l),
      .out_ready(out_ready), .out_sum(sum_l), .out_overflow(ovf_l), .out_index(idx_l)
    );

    function automatic int wrapv(input int v);
      int m;
      int r;
      m = 1 << AW;
      r = v % m;
      if (r < 0) r += m;
      if (r >= m / 2) r -= m;
      return r;
    endfunction

    function automatic bit outside(input int v);
      return (v > MAXV) || (v < MINV);
    endfunction

    int m_acc, m_cnt, m_res, m_idx;
    bit m_ovf, m_rovf, m_hold;
    int p;
    assign p = int'($signed(in_product));

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_acc <= 0; m_cnt <= 0; m_res <= 0; m_idx <= 0;
        m_ovf <= 1'b0; m_rovf <= 1'b0; m_hold <= 1'b0;
      end else if (m_hold) begin
        if (out_ready) begin
          m_hold <= 1'b0; m_idx <= (m_idx + 1) % 256;
          m_acc <= 0; m_cnt <= 0; m_ovf <= 1'b0;
        end
      end else if (flush) begin
        m_acc <= 0; m_cnt <= 0; m_ovf <= 1'b0;
      end else if (in_valid) begin
        if (m_cnt == 3) begin
          m_hold <= 1'b1;
          m_res  <= wrapv(m_acc + p);
          m_rovf <= m_ovf | outside(m_acc + p);
        end else begin
          m_acc <= wrapv(m_acc + p);
          m_ovf <= m_ovf | outside(m_acc + p);
          m_cnt <= m_cnt + 1;
        end
      end
    end

    always @(negedge clk) begin
      if (!rst) begin
        chk($sformatf("w%0d_in_ready", AW), int'(rdy_l), int'(!m_hold));
        chk($sformatf("w%0d_out_valid", AW), int'(vld_l), int'(m_hold));
        chk($sformatf("w%0d_out_index", AW), int'(idx_l), m_idx);
        if (m_hold) begin
          chk($sformatf("w%0d_out_sum", AW), int'($signed(sum_l)), m_res);
          chk($sformatf("w%0d_out_overflow", AW), int'(ovf_l), int'(m_rovf));
        end
      end
    end
  end

  task automatic push(input int v);
    int n;
    n = 0;
    in_valid   = 1'b1;
    in_product = 8'(v);
    while (gen_dut[0].rdy_l == 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("push_wait", (n < 20) ? 1 : 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_vec(input int a, input int b, input int c, input int d);
    push(a); push(b); push(c); push(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; in_valid = 1'b0; in_product = 8'd0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", int'(gen_dut[0].rdy_l), 1);
    chk("rst_out_valid", int'(gen_dut[0].vld_l), 0);
    chk("rst_out_sum", int'(gen_dut[0].sum_l), 0);
    chk("rst_out_overflow", int'(gen_dut[0].ovf_l), 0);
    chk("rst_out_index", int'(gen_dut[0].idx_l), 0);

    // basic vector with backpressure held on the result
    out_ready = 1'b0;
    push_vec(3, 5, -2, 7);
    chk("basic_valid", int'(gen_dut[0].vld_l), 1);
    chk("basic_sum", int'(gen_dut[0].sum_l), 32'h00D);
    chk("basic_ovf", int'(gen_dut[0].ovf_l), 0);
    chk("basic_index", int'(gen_dut[0].idx_l), 0);
    chk("model_basic", gen_dut[0].m_res, 13);
    in_valid = 1'b1; in_product = 8'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", int'(gen_dut[0].rdy_l), 0);
      chk("bp_valid", int'(gen_dut[0].vld_l), 1);
      chk("bp_sum", int'(gen_dut[0].sum_l), 32'h00D);
      chk("bp_index", int'(gen_dut[0].idx_l), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_release_valid", int'(gen_dut[0].vld_l), 0);
    chk("bp_release_ready", int'(gen_dut[0].rdy_l), 1);
    push_vec(1, 1, 1, 1);
    chk("second_sum", int'(gen_dut[0].sum_l), 32'h004);
    chk("second_index", int'(gen_dut[0].idx_l), 1);

    // negative extreme
    push_vec(-128, -128, -128, -128);
    chk("neg_sum", int'(gen_dut[0].sum_l), 32'h200);
    chk("neg_ovf", int'(gen_dut[0].ovf_l), 0);
    chk("model_neg", gen_dut[0].m_res, -512);

    // overflow on the 8-bit instance, then a clean vector
    push_vec(100, 100, 0, 0);
    chk("ovf8_sum", int'(gen_dut[1].sum_l), 32'h0C8);
    chk("ovf8_flag", int'(gen_dut[1].ovf_l), 1);
    chk("ovf10_flag", int'(gen_dut[0].ovf_l), 0);
    chk("model_ovf8", int'(gen_dut[1].m_rovf), 1);
    push_vec(1, 1, 1, 1);
    chk("post_ovf8_sum", int'(gen_dut[1].sum_l), 32'h004);
    chk("post_ovf8_flag", int'(gen_dut[1].ovf_l), 0);
    chk("post_ovf8_index", int'(gen_dut[1].idx_l), 4);

    // flush abort: same-cycle product dropped, index kept
    push(9); push(9);
    flush = 1'b1; in_valid = 1'b1; in_product = 8'd50;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    push_vec(1, 2, 3, 4);
    chk("flush_sum", int'(gen_dut[0].sum_l), 32'h00A);
    chk("flush_index", int'(gen_dut[0].idx_l), 5);

    // reset abort mid-cycle
    push(9); push(9);
    rst = 1'b1;
    #2 rst = 1'b0;
    chk("rst2_index", int'(gen_dut[0].idx_l), 0);
    chk("rst2_valid", int'(gen_dut[0].vld_l), 0);
    push_vec(1, 2, 3, 4);
    chk("rst_abort_sum", int'(gen_dut[0].sum_l), 32'h00A);
    chk("rst_abort_index", int'(gen_dut[0].idx_l), 0);

    // index wrap over 256 further results
    for (int k = 0; k < 256; k++) begin
      push_vec((k % 7) - 3, k % 5, -(k % 3), 2);
      chk("wrap_index", int'(gen_dut[0].idx_l), (k + 1) % 256);
    end

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dot_product_accumulator.md
DOT_PRODUCT_ACCUMULATOR -- requirements
Module: dot_product_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, operand width of the upstream multiplier.
REQ-002 SHALL have parameter VEC_LEN, default 4, number of products summed per result element (range 2..255).
REQ-003 SHALL have parameter ACC_WIDTH, default 10, accumulator and result width (must be at least DATA_WIDTH+4).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  in_product carries a valid product this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts a product this cycle.
REQ-008 SHALL have port in_product  input  DATA_WIDTH+4  signed two's-complement product from the multiplier stage.
REQ-009 SHALL have port flush  input  1  synchronous discard of the partial sum.
REQ-010 SHALL have port out_valid  output  1  out_sum, out_overflow and out_index hold a completed result.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-012 SHALL have port out_sum  output  ACC_WIDTH  signed dot-product result.
REQ-013 SHALL have port out_overflow  output  1  signed overflow occurred while forming out_sum.
REQ-014 SHALL have port out_index  output  8  sequence number of the result, first result is 0.

Function
REQ-015 SHALL implement a two-state FSM: ACCUM and HOLD; reset state ACCUM.
REQ-016 SHALL drive in_ready=1 in ACCUM and in_ready=0 in HOLD, with no combinational path from out_ready to in_ready.
REQ-017 SHALL accept a product when in_valid and in_ready are both 1, sign-extend it to ACC_WIDTH, and add it to the accumulator, with two's-complement wrap.
REQ-018 SHALL keep an element counter (0..VEC_LEN-1) that increments on each accepted product.
REQ-019 SHALL set a sticky overflow flag when an addition has same-sign operands and a result of the opposite sign; the flag clears when a new vector starts.
REQ-020 SHALL, when the product accepted at counter VEC_LEN-1 arrives, register the final sum and overflow into out_sum and out_overflow, set out_valid=1 on the next edge, and enter HOLD (latency: 1 cycle after the last accepted product).
REQ-021 SHALL hold out_sum, out_overflow and out_index stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, in HOLD with out_ready=1, clear out_valid, zero the accumulator, counter and overflow flag, increment out_index (wrapping 255->0), and return to ACCUM on the next edge.
REQ-023 SHALL make minimum throughput one result per VEC_LEN+1 cycles.
REQ-024 SHALL, on flush=1 in ACCUM, zero the accumulator, counter and flag; the same-cycle product is discarded; out_index is unchanged.
REQ-025 SHALL ignore flush in HOLD; the pending result is still delivered.
REQ-026 SHALL ignore in_product and in_valid whenever in_ready=0.

Reset
REQ-027 SHALL, on rst=1 at any time, immediately force ACCUM, accumulator=0, counter=0, flag=0, out_valid=0, out_sum=0, out_overflow=0, out_index=0, in_ready=1 after release; partial and pending results are lost.
REQ-028 SHALL give the first edge after rst deasserts normal behaviour; no extra cycles of latency.

Verification (DATA_WIDTH=4, VEC_LEN=4, ACC_WIDTH=10 unless stated)
REQ-029 SHALL cover this basic case: products 3,5,-2,7 back-to-back with out_ready=1 -> one cycle after the 4th: out_valid=1, out_sum=10'h00D, out_overflow=0, out_index=0.
REQ-030 SHALL cover backpressure: after the result, hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and outputs stable throughout; raise out_ready -> out_valid drops, next vector sums independently with out_index=1.
REQ-031 SHALL cover the negative extreme: four products of -128 (8'h80) -> out_sum=10'h200, out_overflow=0.
REQ-032 SHALL cover overflow with ACC_WIDTH=8: products 100,100,0,0 -> out_sum=8'hC8, out_overflow=1; the next vector 1,1,1,1 -> out_sum=8'h04, out_overflow=0.
REQ-033 SHALL cover abort paths: accept 9,9 then pulse rst (or flush) -> then 1,2,3,4 gives out_sum=10'h00A; after rst out_index=0, after flush out_index is unchanged.
REQ-034 SHALL cover index wrap: stream 257 vectors -> out_index runs 0..255 then 0 on the 257th result.
